mem_stage: RTL and testbench

- MEM pipeline stage of the 5-stage core; the receiving end of the EX→MEM valid/allow_in handshake and of the `to_MEM_data` bus.
- Issues load/store requests on the SRAM-like data port and waits for completion.
- Merges load data with the ALU result and hands `{result, dest, gr_we}` to WB through the same valid/allow_in protocol, one stage further down.

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_stage_sram_if.sv | 60 ++++++
 rtl/mem_stage.sv | 66 ++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int TO_MEM_DATA_WIDTH = 72;
  localparam int TO_WB_DATA_WIDTH  = 38;

  localparam logic [1:0] DATA_SIZE_WORD = 2'b10;

  // Data-port transaction sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } sram_state_t;

  // EX->MEM payload, MSB first
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rkd_value;
    logic        mem_we;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic        gr_we;
  } ex_bus_t;

  // MEM->WB payload, MSB first
  typedef struct packed {
    logic [31:0] final_result;
    logic [4:0]  dest;
    logic        gr_we;
  } wb_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and data-port bundle of the MEM stage. The master side is the
// stage itself; the slave side is the surrounding EX/WB/data-memory world.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                         EX_to_MEM_valid;
  logic [TO_MEM_DATA_WIDTH-1:0] to_MEM_data;
  logic                         MEM_allow_in;
  logic                         WB_allow_in;
  logic                         MEM_to_WB_valid;
  logic [TO_WB_DATA_WIDTH-1:0]  to_WB_data;
  logic                         data_sram_req;
  logic                         data_sram_wr;
  logic [1:0]                   data_sram_size;
  logic [3:0]                   data_sram_wstrb;
  logic [31:0]                  data_sram_addr;
  logic [31:0]                  data_sram_wdata;
  logic                         data_sram_addr_ok;
  logic                         data_sram_data_ok;
  logic [31:0]                  data_sram_rdata;

  modport master (
    input  EX_to_MEM_valid, to_MEM_data, WB_allow_in,
           data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output MEM_allow_in, MEM_to_WB_valid, to_WB_data,
           data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata
  );

  modport slave (
    output EX_to_MEM_valid, to_MEM_data, WB_allow_in,
           data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  MEM_allow_in, MEM_to_WB_valid, to_WB_data,
           data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/mem_stage_sram_if.sv
// Data-port sequencer: one outstanding request at a time, holds load data
// while WB is stalled, and tells the stage when the held op may leave.
module mem_sram_if
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_mem_valid,      // stage holds an instruction
  input  logic        i_mem_op,         // held instruction touches memory
  input  logic        i_capture_mem_op, // a memory op is captured this edge
  input  logic        i_wb_allow_in,
  input  logic        i_addr_ok,
  input  logic        i_data_ok,
  input  logic [31:0] i_rdata,
  output logic        o_req,
  output logic        o_ready_go,
  output logic [31:0] o_load_data
);

  sram_state_t r_state, w_state_nxt;
  logic [31:0] r_rdata_buf;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state: a completing op can hand straight over to a newly captured one
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (i_capture_mem_op) w_state_nxt = S_REQ;
      S_REQ:  if (i_addr_ok)        w_state_nxt = S_WAIT;
      S_WAIT: if (i_data_ok) begin
                if (!i_wb_allow_in)        w_state_nxt = S_DONE;
                else if (i_capture_mem_op) w_state_nxt = S_REQ;
                else                       w_state_nxt = S_IDLE;
              end
      S_DONE: if (i_wb_allow_in) begin
                if (i_capture_mem_op) w_state_nxt = S_REQ;
                else                  w_state_nxt = S_IDLE;
              end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Keep the response while WB is not ready; the bus value is gone next cycle
  always_ff @(posedge clk) begin
    if (!resetn)
      r_rdata_buf <= '0;
    else if (r_state == S_WAIT && i_data_ok && !i_wb_allow_in)
      r_rdata_buf <= i_rdata;
  end

  assign o_req       = i_mem_valid & (r_state == S_REQ);
  assign o_ready_go  = ~i_mem_op | (r_state == S_WAIT & i_data_ok) | (r_state == S_DONE);
  assign o_load_data = (r_state == S_DONE) ? r_rdata_buf : i_rdata;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM capture, data-port access, MEM->WB hand-off.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.master bus
);

  logic        r_mem_valid;
  ex_bus_t     r_ex;
  ex_bus_t     w_ex_in;
  wb_bus_t     w_wb;
  logic        w_ready_go;
  logic        w_allow_in;
  logic        w_capture;
  logic        w_req;
  logic [31:0] w_load_data;

  assign w_ex_in    = bus.to_MEM_data;
  assign w_allow_in = ~r_mem_valid | (w_ready_go & bus.WB_allow_in);
  assign w_capture  = bus.EX_to_MEM_valid & w_allow_in;

  // Stage occupancy
  always_ff @(posedge clk) begin
    if (!resetn)         r_mem_valid <= 1'b0;
    else if (w_allow_in) r_mem_valid <= bus.EX_to_MEM_valid;
  end

  // Payload only moves on an actual transfer from EX
  always_ff @(posedge clk) begin
    if (!resetn)        r_ex <= '0;
    else if (w_capture) r_ex <= w_ex_in;
  end

  mem_sram_if u_sram (
    .clk              (clk),
    .resetn           (resetn),
    .i_mem_valid      (r_mem_valid),
    .i_mem_op         (r_ex.mem_we | r_ex.res_from_mem),
    .i_capture_mem_op (w_capture & (w_ex_in.mem_we | w_ex_in.res_from_mem)),
    .i_wb_allow_in    (bus.WB_allow_in),
    .i_addr_ok        (bus.data_sram_addr_ok),
    .i_data_ok        (bus.data_sram_data_ok),
    .i_rdata          (bus.data_sram_rdata),
    .o_req            (w_req),
    .o_ready_go       (w_ready_go),
    .o_load_data      (w_load_data)
  );

  assign w_wb.final_result = r_ex.res_from_mem ? w_load_data : r_ex.alu_result;
  assign w_wb.dest         = r_ex.dest;
  assign w_wb.gr_we        = r_ex.gr_we;

  assign bus.MEM_allow_in    = w_allow_in;
  assign bus.MEM_to_WB_valid = r_mem_valid & w_ready_go;
  assign bus.to_WB_data      = w_wb;

  assign bus.data_sram_req   = w_req;
  assign bus.data_sram_wr    = r_ex.mem_we;
  assign bus.data_sram_size  = DATA_SIZE_WORD;
  assign bus.data_sram_wstrb = r_ex.mem_we ? 4'hf : 4'h0;
  assign bus.data_sram_addr  = r_ex.alu_result;
  assign bus.data_sram_wdata = r_ex.rkd_value;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed corner sequences, a vector table of ALU ops,
// then random traffic against an in-order instruction/memory reference.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();
  mem_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic ex_bus_t mk(input logic [31:0] alu, input logic [31:0] rkd,
                                 input logic we, input logic rfm,
                                 input logic [4:0] dest, input logic gwe);
    ex_bus_t p;
    p.alu_result = alu; p.rkd_value = rkd; p.mem_we = we;
    p.res_from_mem = rfm; p.dest = dest; p.gr_we = gwe;
    return p;
  endfunction

  // Present one instruction for a single cycle; it must be accepted.
  task automatic capture(input ex_bus_t p);
    bus.EX_to_MEM_valid = 1'b1;
    bus.to_MEM_data = p;
    neg();
    chk("cap_allow_in", bus.MEM_allow_in, 1);
    tick();
    bus.EX_to_MEM_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        gwe;
    logic [37:0] exp_wb;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } rq_t;

  vec_t        tbl[4];
  logic [31:0] ref_mem[8];
  logic [31:0] sim_mem[8];
  wb_bus_t     exp_q[$];
  rq_t         rq_q[$];

  initial begin
    ex_bus_t p;
    wb_bus_t w;
    rq_t     r;
    bit      pend, old_pend, pwr, ex_hold;
    int      cnt, pidx, kind, idx;

    bus.EX_to_MEM_valid = 0; bus.to_MEM_data = '0; bus.WB_allow_in = 1;
    bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 0; bus.data_sram_rdata = 0;

    // ---- reset ----
    tick(); tick();
    neg();
    chk("rst_to_wb_valid", bus.MEM_to_WB_valid, 0);
    chk("rst_allow_in", bus.MEM_allow_in, 1);
    chk("rst_req", bus.data_sram_req, 0);
    tick();
    resetn = 1;

    // ---- ALU op vector table ----
    tbl[0] = '{32'h0000_1234, 5'd5,  1'b1, {32'h0000_1234, 5'd5,  1'b1}};
    tbl[1] = '{32'hFFFF_FFFF, 5'd31, 1'b0, {32'hFFFF_FFFF, 5'd31, 1'b0}};
    tbl[2] = '{32'h0000_0000, 5'd0,  1'b1, {32'h0000_0000, 5'd0,  1'b1}};
    tbl[3] = '{32'h8000_0001, 5'd17, 1'b1, {32'h8000_0001, 5'd17, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      capture(mk(tbl[i].alu, $urandom, 1'b0, 1'b0, tbl[i].dest, tbl[i].gwe));
      neg();
      chk("tbl_valid", bus.MEM_to_WB_valid, 1);
      chk("tbl_wb", bus.to_WB_data, tbl[i].exp_wb);
      chk("tbl_req", bus.data_sram_req, 0);
      tick();
    end
    neg();
    chk("tbl_empty", bus.MEM_to_WB_valid, 0);
    tick();

    // ---- single load, minimum latency ----
    capture(mk(32'h1C00_0040, 32'h0, 1'b0, 1'b1, 5'd3, 1'b1));
    bus.data_sram_addr_ok = 1;
    neg();
    chk("ld_req", bus.data_sram_req, 1);
    chk("ld_addr", bus.data_sram_addr, 32'h1C00_0040);
    chk("ld_ctl", {bus.data_sram_wr, bus.data_sram_wstrb, bus.data_sram_size}, {1'b0, 4'h0, 2'b10});
    tick();
    bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hDEAD_BEEF;
    neg();
    chk("ld_req_once", bus.data_sram_req, 0);
    chk("ld_valid", bus.MEM_to_WB_valid, 1);
    chk("ld_wb", bus.to_WB_data, {32'hDEAD_BEEF, 5'd3, 1'b1});
    tick();
    bus.data_sram_data_ok = 0; bus.data_sram_rdata = 0;
    neg();
    chk("ld_after", bus.MEM_to_WB_valid, 0);
    tick();

    // ---- store with slow addr_ok ----
    capture(mk(32'h1C00_0080, 32'hA5A5_0001, 1'b1, 1'b0, 5'd0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      bus.data_sram_addr_ok = (i == 3);
      neg();
      chk("st_req", bus.data_sram_req, 1);
      chk("st_ctl", {bus.data_sram_wr, bus.data_sram_wstrb, bus.data_sram_size}, {1'b1, 4'hf, 2'b10});
      chk("st_wdata", bus.data_sram_wdata, 32'hA5A5_0001);
      chk("st_addr", bus.data_sram_addr, 32'h1C00_0080);
      chk("st_allow", bus.MEM_allow_in, 0);
      tick();
    end
    bus.data_sram_addr_ok = 0;
    neg();
    chk("st_wait_req", bus.data_sram_req, 0);
    chk("st_wait_allow", bus.MEM_allow_in, 0);
    tick();
    bus.data_sram_data_ok = 1;
    neg();
    chk("st_valid", bus.MEM_to_WB_valid, 1);
    chk("st_allow_done", bus.MEM_allow_in, 1);
    chk("st_wb", bus.to_WB_data, {32'h1C00_0080, 5'd0, 1'b0});
    tick();
    bus.data_sram_data_ok = 0;

    // ---- load under WB back-pressure ----
    capture(mk(32'h1C00_00C0, 32'h0, 1'b0, 1'b1, 5'd7, 1'b1));
    bus.data_sram_addr_ok = 1;
    neg(); tick();
    bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1;
    bus.data_sram_rdata = 32'h1111_2222; bus.WB_allow_in = 0;
    neg();
    chk("bp_valid", bus.MEM_to_WB_valid, 1);
    chk("bp_allow", bus.MEM_allow_in, 0);
    tick();
    bus.data_sram_data_ok = 0; bus.data_sram_rdata = 0;
    for (int i = 0; i < 2; i++) begin
      neg();
      chk("bp_hold_valid", bus.MEM_to_WB_valid, 1);
      chk("bp_hold_data", bus.to_WB_data, {32'h1111_2222, 5'd7, 1'b1});
      chk("bp_hold_req", bus.data_sram_req, 0);
      chk("bp_hold_allow", bus.MEM_allow_in, 0);
      tick();
    end
    bus.WB_allow_in = 1;
    neg();
    chk("bp_rel_data", bus.to_WB_data, {32'h1111_2222, 5'd7, 1'b1});
    chk("bp_rel_allow", bus.MEM_allow_in, 1);
    tick();
    neg();
    chk("bp_after", bus.MEM_to_WB_valid, 0);
    tick();

    // ---- back-to-back loads ----
    capture(mk(32'h1C00_0100, 32'h0, 1'b0, 1'b1, 5'd1, 1'b1));
    bus.data_sram_addr_ok = 1;
    neg();
    chk("b2b_req1_addr", bus.data_sram_addr, 32'h1C00_0100);
    tick();
    bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hCAFE_0001;
    bus.EX_to_MEM_valid = 1; bus.to_MEM_data = mk(32'h1C00_0104, 32'h0, 1'b0, 1'b1, 5'd2, 1'b1);
    neg();
    chk("b2b_allow", bus.MEM_allow_in, 1);
    chk("b2b_wb1", bus.to_WB_data, {32'hCAFE_0001, 5'd1, 1'b1});
    tick();
    bus.EX_to_MEM_valid = 0; bus.data_sram_data_ok = 0; bus.data_sram_addr_ok = 1;
    neg();
    chk("b2b_req2", bus.data_sram_req, 1);
    chk("b2b_req2_addr", bus.data_sram_addr, 32'h1C00_0104);
    chk("b2b_req2_novalid", bus.MEM_to_WB_valid, 0);
    tick();
    bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hCAFE_0002;
    neg();
    chk("b2b_noreq", bus.data_sram_req, 0);
    chk("b2b_wb2", bus.to_WB_data, {32'hCAFE_0002, 5'd2, 1'b1});
    tick();
    bus.data_sram_data_ok = 0;
    neg();
    chk("b2b_after", bus.MEM_to_WB_valid, 0);
    tick();

    // ---- reset while waiting for data ----
    capture(mk(32'h1C00_0140, 32'h0, 1'b0, 1'b1, 5'd4, 1'b1));
    bus.data_sram_addr_ok = 1;
    neg(); tick();
    bus.data_sram_addr_ok = 0;
    neg();
    chk("rw_wait_req", bus.data_sram_req, 0);
    resetn = 0;
    tick();
    resetn = 1;
    neg();
    chk("rw_valid", bus.MEM_to_WB_valid, 0);
    chk("rw_req", bus.data_sram_req, 0);
    chk("rw_allow", bus.MEM_allow_in, 1);
    tick();

    // ---- random traffic against reference ----
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom;
      sim_mem[i] = ref_mem[i];
    end
    pend = 0; cnt = 0; pidx = 0; pwr = 0; ex_hold = 0;
    for (int cyc = 0; cyc < 3060; cyc++) begin
      bus.WB_allow_in = (cyc >= 3000) ? 1'b1 : (($urandom % 10) < 7);
      bus.data_sram_addr_ok = $urandom % 2;
      if (pend && cnt == 1) begin
        bus.data_sram_data_ok = 1;
        bus.data_sram_rdata = pwr ? $urandom : sim_mem[pidx];
      end else begin
        bus.data_sram_data_ok = 0;
        bus.data_sram_rdata = $urandom;
        if (pend) cnt--;
      end
      if (!ex_hold) begin
        kind = $urandom % 3;
        idx = $urandom % 8;
        bus.EX_to_MEM_valid = (cyc < 3000) && (($urandom % 10) < 7);
        case (kind)
          0: p = mk($urandom, $urandom, 1'b0, 1'b0, 5'($urandom), 1'($urandom));
          1: p = mk(32'h1C00_0000 | (idx << 2), $urandom, 1'b0, 1'b1, 5'($urandom), 1'b1);
          default: p = mk(32'h1C00_0000 | (idx << 2), $urandom, 1'b1, 1'b0, 5'($urandom), 1'b0);
        endcase
        bus.to_MEM_data = p;
      end
      neg();
      // WB side
      if (bus.MEM_to_WB_valid && bus.WB_allow_in) begin
        if (exp_q.size() == 0) chk("rnd_wb_extra", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("rnd_wb", bus.to_WB_data, w);
        end
      end
      // data port
      old_pend = pend;
      if (bus.data_sram_data_ok) pend = 0;
      if (bus.data_sram_req) begin
        if (old_pend || rq_q.size() == 0) chk("rnd_req_illegal", 1, 0);
        else begin
          r = rq_q[0];
          chk("rnd_req_addr", bus.data_sram_addr, r.addr);
          chk("rnd_req_ctl", {bus.data_sram_wr, bus.data_sram_wstrb, bus.data_sram_size},
              {r.wr, r.wr ? 4'hf : 4'h0, 2'b10});
          if (r.wr) chk("rnd_req_wdata", bus.data_sram_wdata, r.wdata);
          if (bus.data_sram_addr_ok) begin
            void'(rq_q.pop_front());
            pend = 1; cnt = $urandom_range(1, 3);
            pidx = int'(r.addr[4:2]); pwr = r.wr;
            if (r.wr) sim_mem[pidx] = r.wdata;
          end
        end
      end
      // EX side: program-order reference
      if (bus.EX_to_MEM_valid && bus.MEM_allow_in) begin
        p = bus.to_MEM_data;
        idx = int'(p.alu_result[4:2]);
        w.final_result = p.res_from_mem ? ref_mem[idx] : p.alu_result;
        w.dest = p.dest;
        w.gr_we = p.gr_we;
        exp_q.push_back(w);
        if (p.mem_we) ref_mem[idx] = p.rkd_value;
        if (p.mem_we || p.res_from_mem) begin
          r.addr = p.alu_result; r.wr = p.mem_we; r.wdata = p.rkd_value;
          rq_q.push_back(r);
        end
        ex_hold = 0;
      end else begin
        ex_hold = bus.EX_to_MEM_valid;
      end
      tick();
    end
    chk("rnd_drain_wb", exp_q.size(), 0);
    chk("rnd_drain_req", rq_q.size(), 0);
    chk("rnd_drain_pend", pend, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
